// File: rtl/irq_priority_encoder.sv
// Eight-line active-low interrupt priority encoder with edge latching (or level mode),
// per-line masking and an IDLE/PRESENT/GAP handshake that enforces a 2-cycle Irq_bar high gap.
module irq_priority_encoder #(
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Req_bar,
  input  logic [7:0] Mask,
  input  logic       Ack,
  output logic       Irq_bar,
  output logic [2:0] Vec,
  output logic       Valid
);

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t     state_q, state_d;
  logic [7:0] req_s_q, req_s_d;
  logic [7:0] req_p_q, req_p_d;
  logic [7:0] pending_q, pending_d;
  logic       irq_bar_q, irq_bar_d;
  logic       valid_q, valid_d;
  logic [2:0] vec_q, vec_d;

  logic [7:0] fall;
  logic [7:0] ack_clr;
  logic [7:0] eligible;
  logic [2:0] winner;

  // req_p is the previous sample of req_s, so a 1->0 on req_s is seen one cycle later
  always_comb begin
    req_s_d  = Req_bar;
    req_p_d  = req_s_q;
    fall     = req_p_q & ~req_s_q;
    ack_clr  = '0;
    if (state_q == PRESENT && Ack) ack_clr[vec_q] = 1'b1;
    if (LEVEL_MODE) pending_d = ~req_s_q;
    else            pending_d = (pending_q & ~ack_clr) | fall;  // new edge beats the clear
  end

  always_comb begin
    eligible = pending_q & Mask;
    winner   = '0;
    for (int i = 0; i < 8; i++)
      if (eligible[i]) winner = 3'(i);
  end

  always_comb begin
    state_d   = state_q;
    irq_bar_d = irq_bar_q;
    valid_d   = valid_q;
    vec_d     = vec_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d   = PRESENT;
          vec_d     = winner;
          irq_bar_d = 1'b0;
          valid_d   = 1'b1;
        end
      end
      PRESENT: begin
        if (Ack) begin
          state_d   = GAP;
          irq_bar_d = 1'b1;
          valid_d   = 1'b0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_s_q   <= 8'hFF;
      req_p_q   <= 8'hFF;
      pending_q <= '0;
      irq_bar_q <= 1'b1;
      valid_q   <= 1'b0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_s_q   <= req_s_d;
      req_p_q   <= req_p_d;
      pending_q <= pending_d;
      irq_bar_q <= irq_bar_d;
      valid_q   <= valid_d;
      vec_q     <= vec_d;
    end
  end

  assign Irq_bar = irq_bar_q;
  assign Valid   = valid_q;
  assign Vec     = vec_q;

endmodule
